vga_scan_gen: RTL and testbench

- Raster timing generator that drives the pixel-coordinate side of the display path.
- Scans an 800x525 frame (640x480 active) and emits the signed-flag pixel coordinates consumed by the per-pixel draw blocks.
  - Bit 10 set means outside the active area.
- Re-times hsync/vsync/blanking through a configurable delay line so they align with the draw blocks' registered colour output, then gates the final 12-bit colour to the monitor.

---
 rtl/vga_scan_gen.sv | 189 ++++++++++++++++++
 tb/tb_vga_scan_gen.sv | 225 ++++++++++++++++++++++
 2 files changed

// File: rtl/vga_scan_gen.sv
// VGA raster timing generator: 800x525 scan, x/y pixel coordinates, re-timed sync/blank, gated colour.
// Latency: x/y decode is combinational; hs/vs lag the counters by PIPE_DELAY clks, rgb_out by PIPE_DELAY+1.
// No backpressure: counters advance only on pix_en; optional colour-bar generator under TEST_PATTERN_EN.
module vga_scan_gen #(
   parameter int H_ACTIVE   = 640,
   parameter int H_FP       = 16,
   parameter int H_SYNC     = 96,
   parameter int H_BP       = 48,
   parameter int V_ACTIVE   = 480,
   parameter int V_FP       = 10,
   parameter int V_SYNC     = 2,
   parameter int V_BP       = 33,
   parameter int PIPE_DELAY = 1
) (
   input  logic        clk,
   input  logic        rst,
   input  logic        pix_en,
   output logic [10:0] x,
   output logic [10:0] y,
   input  logic [11:0] rgb_in,
   input  logic        pattern_sel,
   output logic        hs,
   output logic        vs,
   output logic [11:0] rgb_out,
   output logic        frame_start
);

   localparam int H_TOTAL = H_ACTIVE + H_FP + H_SYNC + H_BP;
   localparam int V_TOTAL = V_ACTIVE + V_FP + V_SYNC + V_BP;

   localparam logic [9:0] H_LAST = 10'(H_TOTAL - 1);
   localparam logic [9:0] V_LAST = 10'(V_TOTAL - 1);
   localparam logic [9:0] H_ACT  = 10'(H_ACTIVE);
   localparam logic [9:0] V_ACT  = 10'(V_ACTIVE);
   localparam logic [9:0] HS_BEG = 10'(H_ACTIVE + H_FP);
   localparam logic [9:0] HS_END = 10'(H_ACTIVE + H_FP + H_SYNC);
   localparam logic [9:0] VS_BEG = 10'(V_ACTIVE + V_FP);
   localparam logic [9:0] VS_END = 10'(V_ACTIVE + V_FP + V_SYNC);

   logic [9:0]  h_cnt;
   logic [9:0]  v_cnt;
   logic        h_last;
   logic        v_last;
   logic        hs_raw;
   logic        vs_raw;
   logic        video_on_raw;
   logic        hs_d;
   logic        vs_d;
   logic        video_on_d;
   logic [11:0] pix_col;

   assign h_last = (h_cnt == H_LAST);
   assign v_last = (v_cnt == V_LAST);

   // Scan counters; frame_start marks the tick that wraps the raster back to (0,0)
   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         h_cnt       <= '0;
         v_cnt       <= '0;
         frame_start <= 1'b0;
      end else begin
         frame_start <= pix_en && h_last && v_last;
         if (pix_en) begin
            if (h_last) begin
               h_cnt <= '0;
               v_cnt <= v_last ? '0 : v_cnt + 10'd1;
            end else begin
               h_cnt <= h_cnt + 10'd1;
            end
         end
      end
   end

   // Coordinate decode: bit 10 flags blanking on that axis only
   always_comb begin
      x = (h_cnt < H_ACT) ? {1'b0, h_cnt} : 11'h400;
      y = (v_cnt < V_ACT) ? {1'b0, v_cnt} : 11'h400;
   end

   // Raw sync/blank straight from the counters
   always_comb begin
      hs_raw       = !((h_cnt >= HS_BEG) && (h_cnt < HS_END));
      vs_raw       = !((v_cnt >= VS_BEG) && (v_cnt < VS_END));
      video_on_raw = (h_cnt < H_ACT) && (v_cnt < V_ACT);
   end

`ifdef TEST_PATTERN_EN
   // h_cnt travels with the blanking so bar colours line up with video_on_d
   logic [9:0] hc_d;
`endif

   generate
      if (PIPE_DELAY == 0) begin : g_direct
         assign hs_d       = hs_raw;
         assign vs_d       = vs_raw;
         assign video_on_d = video_on_raw;
`ifdef TEST_PATTERN_EN
         assign hc_d       = h_cnt;
`endif
      end else begin : g_pipe
         logic [PIPE_DELAY-1:0] hs_sr;
         logic [PIPE_DELAY-1:0] vs_sr;
         logic [PIPE_DELAY-1:0] vid_sr;
`ifdef TEST_PATTERN_EN
         logic [9:0] hc_sr [PIPE_DELAY];
`endif

         // Free-running delay line, clocked every clk regardless of pix_en
         always_ff @(posedge clk or negedge rst) begin
            if (!rst) begin
               hs_sr  <= '1;
               vs_sr  <= '1;
               vid_sr <= '0;
`ifdef TEST_PATTERN_EN
               for (int i = 0; i < PIPE_DELAY; i++) hc_sr[i] <= '0;
`endif
            end else begin
               hs_sr[0]  <= hs_raw;
               vs_sr[0]  <= vs_raw;
               vid_sr[0] <= video_on_raw;
`ifdef TEST_PATTERN_EN
               hc_sr[0]  <= h_cnt;
`endif
               for (int i = 1; i < PIPE_DELAY; i++) begin
                  hs_sr[i]  <= hs_sr[i-1];
                  vs_sr[i]  <= vs_sr[i-1];
                  vid_sr[i] <= vid_sr[i-1];
`ifdef TEST_PATTERN_EN
                  hc_sr[i]  <= hc_sr[i-1];
`endif
               end
            end
         end

         assign hs_d       = hs_sr[PIPE_DELAY-1];
         assign vs_d       = vs_sr[PIPE_DELAY-1];
         assign video_on_d = vid_sr[PIPE_DELAY-1];
`ifdef TEST_PATTERN_EN
         assign hc_d       = hc_sr[PIPE_DELAY-1];
`endif
      end
   endgenerate

   assign hs = hs_d;
   assign vs = vs_d;

`ifdef TEST_PATTERN_EN
   localparam int         BAR_W = H_ACTIVE / 8;
   localparam logic [9:0] B1 = 10'(1 * BAR_W);
   localparam logic [9:0] B2 = 10'(2 * BAR_W);
   localparam logic [9:0] B3 = 10'(3 * BAR_W);
   localparam logic [9:0] B4 = 10'(4 * BAR_W);
   localparam logic [9:0] B5 = 10'(5 * BAR_W);
   localparam logic [9:0] B6 = 10'(6 * BAR_W);
   localparam logic [9:0] B7 = 10'(7 * BAR_W);

   function automatic logic [11:0] bar_color(input logic [9:0] hc);
      if      (hc < B1) return 12'hFFF;
      else if (hc < B2) return 12'hFF0;
      else if (hc < B3) return 12'h0FF;
      else if (hc < B4) return 12'h0F0;
      else if (hc < B5) return 12'hF0F;
      else if (hc < B6) return 12'hF00;
      else if (hc < B7) return 12'h00F;
      else              return 12'h000;
   endfunction

   // Colour source: external draw logic or the built-in bars
   always_comb begin
      pix_col = rgb_in;
      if (pattern_sel) pix_col = bar_color(hc_d);
   end
`else
   logic unused_pattern_sel;
   assign unused_pattern_sel = pattern_sel;

   // Colour source: external draw logic only
   always_comb begin
      pix_col = rgb_in;
   end
`endif

   // Final colour register, blanked outside the delayed active window
   always_ff @(posedge clk or negedge rst) begin
      if (!rst) rgb_out <= '0;
      else      rgb_out <= video_on_d ? pix_col : 12'h000;
   end

endmodule

// File: tb/tb_vga_scan_gen.sv
// Directed bench for vga_scan_gen: default timing (PIPE_DELAY 1 and 0) plus a shrunken raster for frame checks.
module tb_vga_scan_gen;

   logic        clk;
   logic        rst;
   logic        pix_en;
   logic        pix_en_b;
   logic [11:0] rgb_in;
   logic        pattern_sel;

   logic [10:0] x_a, y_a, x_c, y_c, x_b, y_b;
   logic        hs_a, vs_a, fs_a, hs_c, vs_c, fs_c, hs_b, vs_b, fs_b;
   logic [11:0] rgb_a, rgb_c, rgb_b;

   int n_vec = 0;
   int n_bad = 0;
   int fs_a_seen = 0;

   vga_scan_gen u_a (
      .clk(clk), .rst(rst), .pix_en(pix_en), .x(x_a), .y(y_a), .rgb_in(rgb_in),
      .pattern_sel(pattern_sel), .hs(hs_a), .vs(vs_a), .rgb_out(rgb_a), .frame_start(fs_a)
   );

   vga_scan_gen #(.PIPE_DELAY(0)) u_c (
      .clk(clk), .rst(rst), .pix_en(pix_en), .x(x_c), .y(y_c), .rgb_in(rgb_in),
      .pattern_sel(pattern_sel), .hs(hs_c), .vs(vs_c), .rgb_out(rgb_c), .frame_start(fs_c)
   );

   // 15 x 8 raster (8x4 active) so whole frames fit in a short run
   vga_scan_gen #(
      .H_ACTIVE(8), .H_FP(2), .H_SYNC(3), .H_BP(2),
      .V_ACTIVE(4), .V_FP(1), .V_SYNC(2), .V_BP(1), .PIPE_DELAY(1)
   ) u_b (
      .clk(clk), .rst(rst), .pix_en(pix_en_b), .x(x_b), .y(y_b), .rgb_in(rgb_in),
      .pattern_sel(pattern_sel), .hs(hs_b), .vs(vs_b), .rgb_out(rgb_b), .frame_start(fs_b)
   );

   initial begin
      clk = 1'b0;
      forever #5 clk = ~clk;
   end

   always @(negedge clk) if (fs_a) fs_a_seen++;

   task automatic check(input string name, input int act, input int exp);
      n_vec++;
      if (act != exp) begin
         n_bad++;
         $display("FAIL %s: got %0h, expected %0h", name, act, exp);
      end
   endtask

   // n pixel ticks at one tick per four clks; returns #1 after a posedge
   task automatic ticks(input int n);
      for (int i = 0; i < n; i++) begin
         pix_en = 1'b1;
         @(posedge clk); #1;
         pix_en = 1'b0;
         repeat (3) @(posedge clk);
         #1;
      end
   endtask

   // n back-to-back ticks, then three idle clks so the delay line settles
   task automatic run(input int n);
      if (n > 0) begin
         pix_en = 1'b1;
         repeat (n) @(posedge clk);
         #1;
         pix_en = 1'b0;
      end
      repeat (3) @(posedge clk);
      #1;
   endtask

   // One tick, then rgb_out of both delay variants checked on each of the next three clks
   task automatic edge_seq(input string name, input int a0, input int c0, input int a1,
                           input int c1, input int a2);
      pix_en = 1'b1;
      @(posedge clk); #1;
      pix_en = 1'b0;
      check({name, "_a0"}, int'(rgb_a), a0);
      check({name, "_c0"}, int'(rgb_c), c0);
      @(posedge clk); #1;
      check({name, "_a1"}, int'(rgb_a), a1);
      check({name, "_c1"}, int'(rgb_c), c1);
      @(posedge clk); #1;
      check({name, "_a2"}, int'(rgb_a), a2);
   endtask

   typedef struct {
      int adv;
      int ex;
      int ey;
      int ehs;
      int evs;
      int ergb;
   } vec_t;

   vec_t tbl[10];

   initial begin
      int n_fs, fs_first, fs_last, vs_low, vs_first;

      tbl[0] = '{0,   'h000, 0, 1, 1, 'hABC};
      tbl[1] = '{639, 'h27F, 0, 1, 1, 'hABC};
      tbl[2] = '{1,   'h400, 0, 1, 1, 'h000};
      tbl[3] = '{15,  'h400, 0, 1, 1, 'h000};
      tbl[4] = '{1,   'h400, 0, 0, 1, 'h000};
      tbl[5] = '{95,  'h400, 0, 0, 1, 'h000};
      tbl[6] = '{1,   'h400, 0, 1, 1, 'h000};
      tbl[7] = '{47,  'h400, 0, 1, 1, 'h000};
      tbl[8] = '{1,   'h000, 1, 1, 1, 'hABC};
      tbl[9] = '{5,   'h005, 1, 1, 1, 'hABC};

      rst         = 1'b1;
      pix_en      = 1'b0;
      pix_en_b    = 1'b0;
      rgb_in      = 12'hABC;
      pattern_sel = 1'b0;
      #1 rst = 1'b0;
      #1;
      check("rst_x",   int'(x_a),   0);
      check("rst_y",   int'(y_a),   0);
      check("rst_hs",  int'(hs_a),  1);
      check("rst_vs",  int'(vs_a),  1);
      check("rst_rgb", int'(rgb_a), 0);
      check("rst_fs",  int'(fs_a),  0);
      repeat (2) @(posedge clk);
      #1 rst = 1'b1;
      repeat (3) @(posedge clk);
      #1;

      // Line scan at one tick per four clks
      for (int i = 0; i < 10; i++) begin
         ticks(tbl[i].adv);
         check($sformatf("v%0d_x", i),   int'(x_a),   tbl[i].ex);
         check($sformatf("v%0d_y", i),   int'(y_a),   tbl[i].ey);
         check($sformatf("v%0d_hs", i),  int'(hs_a),  tbl[i].ehs);
         check($sformatf("v%0d_vs", i),  int'(vs_a),  tbl[i].evs);
         check($sformatf("v%0d_rgb", i), int'(rgb_a), tbl[i].ergb);
      end

      // Colour latency into blanking (639 -> 640) and back into active (799 -> 0)
      run(634);
      check("pre_blank_x", int'(x_a), 'h27F);
      edge_seq("to_blank", 'hABC, 'hABC, 'hABC, 'h000, 'h000);
      run(159);
      check("pre_active_x", int'(x_a), 'h400);
      edge_seq("to_active", 'h000, 'h000, 'h000, 'hABC, 'hABC);
      check("line2_y", int'(y_a), 2);

      // Asynchronous reset in the middle of a line
      run(300);
      check("mid_x", int'(x_a), 300);
      check("mid_rgb", int'(rgb_a), 'hABC);
      #2 rst = 1'b0;
      #1;
      check("arst_x",     int'(x_a),   0);
      check("arst_y",     int'(y_a),   0);
      check("arst_hs",    int'(hs_a),  1);
      check("arst_vs",    int'(vs_a),  1);
      check("arst_rgb",   int'(rgb_a), 0);
      check("arst_rgb_c", int'(rgb_c), 0);
      fs_a_seen = 0;
      repeat (3) @(posedge clk);
      #1 rst = 1'b1;
      check("rel_x", int'(x_a), 0);
      check("rel_y", int'(y_a), 0);
      ticks(3);
      check("rel_x3", int'(x_a), 3);
      check("rel_no_fs", fs_a_seen, 0);

      // Frame timing on the small raster: sample c sees counters at tick c
      n_fs = 0; fs_first = -1; fs_last = -1; vs_low = 0; vs_first = -1;
      pix_en_b = 1'b1;
      for (int c = 0; c < 260; c++) begin
         @(negedge clk);
         if (fs_b) begin
            n_fs++;
            if (fs_first < 0) fs_first = c;
            fs_last = c;
            check("fs_at_x0", int'(x_b), 0);
            check("fs_at_y0", int'(y_b), 0);
         end
         if (!vs_b) begin
            vs_low++;
            if (vs_first < 0) vs_first = c;
         end
      end
      pix_en_b = 1'b0;
      check("fs_count",  n_fs,     2);
      check("fs_first",  fs_first, 120);
      check("fs_period", fs_last - fs_first, 120);
      check("vs_low_clks", vs_low, 60);
      check("vs_first",  vs_first, 76);

`ifdef TEST_PATTERN_EN
      @(posedge clk); #1;
      rst = 1'b0;
      @(posedge clk); #1;
      rst = 1'b1;
      pattern_sel = 1'b1;
      run(0);
      check("bar_x0",   int'(rgb_a), 'hFFF);
      run(79);
      check("bar_x79",  int'(rgb_a), 'hFFF);
      run(1);
      check("bar_x80",  int'(rgb_a), 'hFF0);
      run(79);
      check("bar_x159", int'(rgb_a), 'hFF0);
      run(321);
      check("bar_x480", int'(rgb_a), 'h00F);
      run(80);
      check("bar_x560", int'(rgb_a), 'h000);
      run(79);
      check("bar_x639", int'(rgb_a), 'h000);
      pattern_sel = 1'b0;
`endif

      $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
      $finish;
   end

endmodule
